train_center_cal_tx: RTL and testbench
======================================

# train_center_cal_tx

Initiator side of the MBTRAIN train-center-calibration handshake. It sends the start request over the sideband and waits for the partner's start response. It then runs the local point test or eye-width sweep, exchanges the end request/response, and raises a done acknowledge to the MBTRAIN sequencer. It shares the sideband transmit mux with the partner-response FSM, arbitrating through the valid/busy signals.

## Interface
- TIMEOUT_CYCLES, 8000000: cycles allowed in each WAIT_* state before abort; 0 disables the timeout.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_en  in  1  block enable from MBTRAIN sequencer; low forces IDLE on the next edge.
- i_decoded_sideband_message  in  4  decoded received message: 0010 start resp, 0100 end resp.
- i_sideband_valid  in  1  qualifies i_decoded_sideband_message for one cycle.
- i_busy_negedge_detected  in  1  sideband serializer finished the current message.
- i_valid_rx  in  1  response FSM currently owns the sideband mux.
- i_lfsr_or_perlane  in  1  0 = LFSR test, 1 = per-lane test.
- i_pt_done  in  1  point-test/sweep engine completed.
- i_tx_lanes_result  in  16  per-lane pass mask from the test engine.
- o_sideband_message  out  4  message to send: 0001 start req, 0011 end req.
- o_valid_tx  out  1  request for the sideband mux.
- o_pt_en  out  1  point-test engine enable.
- o_eye_width_sweep_en  out  1  sweep enable.
- o_lanes_result  out  16  latched lane mask.
- o_test_ack  out  1  test complete, including the abort case.
- o_timeout  out  1  abort flag.

## Operation
- States: IDLE, SEND_START_REQ, WAIT_START_RESP, POINT_TEST, SEND_END_REQ, WAIT_END_RESP, TEST_FINISHED.
- IDLE -> SEND_START_REQ when i_en=1. On entry, o_sideband_message=0001.
- SEND_START_REQ -> WAIT_START_RESP on a falling edge of o_valid_tx, detected against a one-cycle registered copy.
- WAIT_START_RESP -> POINT_TEST on i_sideband_valid && message==0010. Any other message is ignored.
- POINT_TEST: o_pt_en=1. o_eye_width_sweep_en=1 only when i_lfsr_or_perlane=0.
- POINT_TEST -> SEND_END_REQ on i_pt_done. In that same cycle, latch i_tx_lanes_result, drop both enables, and set the message to 0011.
- SEND_END_REQ -> WAIT_END_RESP on a falling edge of o_valid_tx.
- WAIT_END_RESP -> TEST_FINISHED on i_sideband_valid && message==0100. The message goes to 0000 and o_test_ack is set.
- TEST_FINISHED holds all outputs until i_en=0, then goes to IDLE.
- Timeout counter: cleared on entry to each WAIT_* state and incremented each cycle in the state. Width is $clog2(TIMEOUT_CYCLES+1). When it reaches TIMEOUT_CYCLES-1 the FSM goes to TEST_FINISHED with o_timeout=1 and o_test_ack=1.
- Valid arbitration:
  - A pending flag sets on entry to either SEND_* state.
  - o_valid_tx rises when pending=1 and i_valid_rx=0.
  - o_valid_tx and pending both clear on i_busy_negedge_detected.
  - The TX side has priority: the response FSM defers while o_valid_tx=1.

## Timing
- All outputs reset to 0, and state resets to IDLE. i_en=0 mid-operation has the same effect one edge later, including clearing pending, the counter and o_lanes_result.
- IDLE to o_valid_tx high: 2 cycles when i_valid_rx=0. o_sideband_message is stable on or before the edge o_valid_tx rises.
- Falling-edge detect adds 1 cycle after o_valid_tx drops.
- A response arriving while still in SEND_* is ignored; the partner never responds before the request is sent.
- i_pt_done together with i_en=0: reset wins.
- i_busy_negedge_detected while pending and i_valid_rx=1: this edge belongs to the partner's message. The pending flag stays set and o_valid_tx rises the cycle after i_valid_rx falls.

## Structure
- Shared MBTRAIN package: sideband message codes (0001/0010/0011/0100), the state encoding, and the TIMEOUT_CYCLES default.
- Sub-module sb_valid_arbiter: pending flag, o_valid_tx, registered copy and falling-edge detect. It is reusable by the partner FSM.

## Test plan
- Nominal per-lane run: i_en=1, partner replies 0010 then 0100, i_pt_done with mask 16'hFFF0 -> messages 0001 then 0011, o_pt_en=1 with sweep=0, o_lanes_result=16'hFFF0, o_test_ack=1.
- LFSR mode (i_lfsr_or_perlane=0) -> o_eye_width_sweep_en=1 throughout POINT_TEST, and 0 once i_pt_done is seen.
- i_valid_rx held high 5 cycles when SEND_START_REQ is entered -> o_valid_tx stays low, then rises 1 cycle after i_valid_rx falls.
- Wrong message 0100 while in WAIT_START_RESP -> no transition; the following 0010 advances the FSM.
- TIMEOUT_CYCLES=16 and no response -> o_timeout=1 and o_test_ack=1 exactly 16 cycles after entering WAIT_START_RESP.
- i_en dropped during POINT_TEST -> next edge shows IDLE with all outputs 0; re-enabling restarts with 0001.

Source files
------------

// File: rtl/train_center_cal_tx_pkg.sv
// Shared MBTRAIN definitions for the train-center-calibration initiator:
// sideband message codes, FSM state encoding, timeout default and output bundle.
package train_center_cal_tx_pkg;

    localparam int unsigned TC_TIMEOUT_DEFAULT = 8000000;

    typedef enum logic [3:0] {
        SB_NONE       = 4'b0000,
        SB_START_REQ  = 4'b0001,
        SB_START_RESP = 4'b0010,
        SB_END_REQ    = 4'b0011,
        SB_END_RESP   = 4'b0100
    } sb_msg_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_START_REQ,
        ST_WAIT_START_RESP,
        ST_POINT_TEST,
        ST_SEND_END_REQ,
        ST_WAIT_END_RESP,
        ST_TEST_FINISHED
    } tc_state_e;

    typedef struct packed {
        logic [3:0]  msg;
        logic        pt_en;
        logic        sweep_en;
        logic [15:0] lanes;
        logic        test_ack;
        logic        timeout;
    } tc_out_t;

    function automatic logic is_send(input tc_state_e s);
        return (s == ST_SEND_START_REQ) || (s == ST_SEND_END_REQ);
    endfunction

    function automatic logic is_wait(input tc_state_e s);
        return (s == ST_WAIT_START_RESP) || (s == ST_WAIT_END_RESP);
    endfunction

endpackage

// File: rtl/train_center_cal_tx_sb_valid_arbiter.sv
// Sideband transmit-mux request: pending flag, valid, and valid falling-edge
// detect. The TX side keeps the mux once it has it; the partner FSM defers.
module sb_valid_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic start,
    input  logic busy_negedge,
    input  logic valid_rx,
    output logic valid_tx,
    output logic valid_fall
);

    logic pending_q;
    logic valid_q;
    logic valid_d1_q;

    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // updates use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pending_q  <= 1'b0;
            valid_q    <= 1'b0;
            valid_d1_q <= 1'b0;
        end else begin
            valid_d1_q <= valid_q;

            // A busy edge only retires our request if we actually own the mux.
            if (start) begin
                pending_q <= 1'b1;
            end else if (busy_negedge && valid_q) begin
                pending_q <= 1'b0;
            end

            if (valid_q) begin
                if (busy_negedge) begin
                    valid_q <= 1'b0;
                end
            end else if (pending_q && !valid_rx) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign valid_tx   = valid_q;
    assign valid_fall = valid_d1_q && !valid_q;

endmodule

// File: rtl/train_center_cal_tx.sv
// MBTRAIN train-center-calibration initiator: start req/resp handshake,
// local point test or eye sweep, end req/resp, then done acknowledge.
module train_center_cal_tx
    import train_center_cal_tx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TC_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [3:0]  i_decoded_sideband_message,
    input  logic        i_sideband_valid,
    input  logic        i_busy_negedge_detected,
    input  logic        i_valid_rx,
    input  logic        i_lfsr_or_perlane,
    input  logic        i_pt_done,
    input  logic [15:0] i_tx_lanes_result,
    output logic [3:0]  o_sideband_message,
    output logic        o_valid_tx,
    output logic        o_pt_en,
    output logic        o_eye_width_sweep_en,
    output logic [15:0] o_lanes_result,
    output logic        o_test_ack,
    output logic        o_timeout
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    tc_state_e        state_q, state_d;
    tc_out_t          out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             send_start;
    logic             valid_fall;
    logic             timeout_hit;
    logic             resp_start;
    logic             resp_end;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    assign resp_start  = i_sideband_valid && (i_decoded_sideband_message == SB_START_RESP);
    assign resp_end    = i_sideband_valid && (i_decoded_sideband_message == SB_END_RESP);

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;

        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d   = ST_SEND_START_REQ;
                    out_d.msg = SB_START_REQ;
                end
            end
            ST_SEND_START_REQ: begin
                if (valid_fall) begin
                    state_d = ST_WAIT_START_RESP;
                end
            end
            ST_WAIT_START_RESP: begin
                if (resp_start) begin
                    state_d        = ST_POINT_TEST;
                    out_d.pt_en    = 1'b1;
                    out_d.sweep_en = !i_lfsr_or_perlane;
                end else if (timeout_hit) begin
                    state_d        = ST_TEST_FINISHED;
                    out_d.msg      = SB_NONE;
                    out_d.test_ack = 1'b1;
                    out_d.timeout  = 1'b1;
                end
            end
            ST_POINT_TEST: begin
                if (i_pt_done) begin
                    state_d        = ST_SEND_END_REQ;
                    out_d.pt_en    = 1'b0;
                    out_d.sweep_en = 1'b0;
                    out_d.lanes    = i_tx_lanes_result;
                    out_d.msg      = SB_END_REQ;
                end else begin
                    out_d.pt_en    = 1'b1;
                    out_d.sweep_en = !i_lfsr_or_perlane;
                end
            end
            ST_SEND_END_REQ: begin
                if (valid_fall) begin
                    state_d = ST_WAIT_END_RESP;
                end
            end
            ST_WAIT_END_RESP: begin
                if (resp_end) begin
                    state_d        = ST_TEST_FINISHED;
                    out_d.msg      = SB_NONE;
                    out_d.test_ack = 1'b1;
                end else if (timeout_hit) begin
                    state_d        = ST_TEST_FINISHED;
                    out_d.msg      = SB_NONE;
                    out_d.test_ack = 1'b1;
                    out_d.timeout  = 1'b1;
                end
            end
            ST_TEST_FINISHED: begin
                state_d = ST_TEST_FINISHED;
            end
            default: begin
                state_d = ST_IDLE;
                out_d   = '0;
            end
        endcase

        // Dropping the enable wins over anything the state decided this cycle.
        if (!i_en) begin
            state_d = ST_IDLE;
            out_d   = '0;
        end
    end

    // Counter restarts on every state change and only runs inside WAIT_*.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && is_wait(state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign send_start = is_send(state_d) && (state_d != state_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    sb_valid_arbiter u_valid_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (!i_en),
        .start        (send_start),
        .busy_negedge (i_busy_negedge_detected),
        .valid_rx     (i_valid_rx),
        .valid_tx     (o_valid_tx),
        .valid_fall   (valid_fall)
    );

    assign o_sideband_message   = out_q.msg;
    assign o_pt_en              = out_q.pt_en;
    assign o_eye_width_sweep_en = out_q.sweep_en;
    assign o_lanes_result       = out_q.lanes;
    assign o_test_ack           = out_q.test_ack;
    assign o_timeout            = out_q.timeout;

endmodule

// File: tb/tb_train_center_cal_tx.sv
// Self-checking bench for train_center_cal_tx: protocol-level model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_train_center_cal_tx;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic [3:0]  i_decoded_sideband_message = 4'h0;
    logic        i_sideband_valid = 1'b0;
    logic        i_busy_negedge_detected = 1'b0;
    logic        i_valid_rx = 1'b0;
    logic        i_lfsr_or_perlane = 1'b0;
    logic        i_pt_done = 1'b0;
    logic [15:0] i_tx_lanes_result = 16'h0;
    logic [3:0]  o_sideband_message;
    logic        o_valid_tx;
    logic        o_pt_en;
    logic        o_eye_width_sweep_en;
    logic [15:0] o_lanes_result;
    logic        o_test_ack;
    logic        o_timeout;

    int n_checks = 0;
    int n_fail = 0;
    bit check_on = 1'b0;

    train_center_cal_tx #(.TIMEOUT_CYCLES(T)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .i_en                       (i_en),
        .i_decoded_sideband_message (i_decoded_sideband_message),
        .i_sideband_valid           (i_sideband_valid),
        .i_busy_negedge_detected    (i_busy_negedge_detected),
        .i_valid_rx                 (i_valid_rx),
        .i_lfsr_or_perlane          (i_lfsr_or_perlane),
        .i_pt_done                  (i_pt_done),
        .i_tx_lanes_result          (i_tx_lanes_result),
        .o_sideband_message         (o_sideband_message),
        .o_valid_tx                 (o_valid_tx),
        .o_pt_en                    (o_pt_en),
        .o_eye_width_sweep_en       (o_eye_width_sweep_en),
        .o_lanes_result             (o_lanes_result),
        .o_test_ack                 (o_test_ack),
        .o_timeout                  (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- protocol model ----------------
    // Phases: 0 idle, 1 start request out, 2 awaiting start resp, 3 testing,
    // 4 end request out, 5 awaiting end resp, 6 finished.
    int          ph = 0;
    int          m_wait = 0;
    logic [3:0]  m_msg = 4'h0;
    logic        m_pt = 1'b0, m_sweep = 1'b0, m_ack = 1'b0, m_to = 1'b0;
    logic        m_vtx = 1'b0, m_vtx_prev = 1'b0, m_want = 1'b0;
    logic [15:0] m_lanes = 16'h0;

    always @(posedge clk) begin
        logic fell, nxt_vtx, nxt_want;
        int   nxt_ph;
        if (!rst_n || !i_en) begin
            ph = 0; m_wait = 0; m_msg = 4'h0; m_pt = 1'b0; m_sweep = 1'b0;
            m_ack = 1'b0; m_to = 1'b0; m_vtx = 1'b0; m_vtx_prev = 1'b0;
            m_want = 1'b0; m_lanes = 16'h0;
        end else begin
            fell     = m_vtx_prev && !m_vtx;
            nxt_vtx  = m_vtx ? !i_busy_negedge_detected : (m_want && !i_valid_rx);
            nxt_want = m_want && !(m_vtx && i_busy_negedge_detected);
            nxt_ph   = ph;
            case (ph)
                0: begin nxt_ph = 1; m_msg = 4'h1; nxt_want = 1'b1; end
                1, 4: if (fell) begin nxt_ph = ph + 1; m_wait = 0; end
                2, 5: begin
                    if (i_sideband_valid && i_decoded_sideband_message == ((ph == 2) ? 4'h2 : 4'h4)) begin
                        if (ph == 2) begin
                            nxt_ph = 3; m_pt = 1'b1; m_sweep = !i_lfsr_or_perlane;
                        end else begin
                            nxt_ph = 6; m_msg = 4'h0; m_ack = 1'b1;
                        end
                    end else begin
                        m_wait++;
                        if (m_wait == T) begin
                            nxt_ph = 6; m_msg = 4'h0; m_ack = 1'b1; m_to = 1'b1;
                        end
                    end
                end
                3: begin
                    if (i_pt_done) begin
                        nxt_ph = 4; m_pt = 1'b0; m_sweep = 1'b0;
                        m_lanes = i_tx_lanes_result; m_msg = 4'h3; nxt_want = 1'b1;
                    end else begin
                        m_sweep = !i_lfsr_or_perlane;
                    end
                end
                default: ;
            endcase
            m_vtx_prev = m_vtx;
            m_vtx      = nxt_vtx;
            m_want     = nxt_want;
            ph         = nxt_ph;
        end
    end

    // ---------------- per-cycle compare + message log ----------------
    logic [3:0] msg_log[$];
    logic       vtx_seen = 1'b0;

    always @(negedge clk) begin
        if (check_on) begin
            check("cyc_msg",    o_sideband_message,   m_msg);
            check("cyc_vtx",    o_valid_tx,           m_vtx);
            check("cyc_pt_en",  o_pt_en,              m_pt);
            check("cyc_sweep",  o_eye_width_sweep_en, m_sweep);
            check("cyc_lanes",  o_lanes_result,       m_lanes);
            check("cyc_ack",    o_test_ack,           m_ack);
            check("cyc_timeout", o_timeout,           m_to);
            if (o_valid_tx === 1'b1 && !vtx_seen) msg_log.push_back(o_sideband_message);
            vtx_seen = (o_valid_tx === 1'b1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the request to own the mux, then end its message.
    task automatic serialize(input int hold);
        int n = 0;
        while (o_valid_tx !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        check("valid_tx_seen", o_valid_tx, 1'b1);
        if (hold > 0) tick(hold);
        i_busy_negedge_detected = 1'b1;
        tick(1);
        i_busy_negedge_detected = 1'b0;
    endtask

    task automatic respond(input logic [3:0] code);
        tick(2);
        i_sideband_valid = 1'b1;
        i_decoded_sideband_message = code;
        tick(1);
        i_sideband_valid = 1'b0;
        i_decoded_sideband_message = 4'h0;
    endtask

    task automatic pt_done(input logic [15:0] mask);
        i_pt_done = 1'b1;
        i_tx_lanes_result = mask;
        tick(1);
        i_pt_done = 1'b0;
        i_tx_lanes_result = 16'h0;
    endtask

    task automatic disable_block();
        i_en = 1'b0;
        tick(1);
        check("off_msg",   o_sideband_message, 4'h0);
        check("off_vtx",   o_valid_tx, 1'b0);
        check("off_pt",    o_pt_en, 1'b0);
        check("off_lanes", o_lanes_result, 16'h0);
        check("off_ack",   o_test_ack, 1'b0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        check_on = 1'b1;
        tick(1);
        check("rst_msg",   o_sideband_message, 4'h0);
        check("rst_vtx",   o_valid_tx, 1'b0);
        check("rst_ack",   o_test_ack, 1'b0);
        check("rst_lanes", o_lanes_result, 16'h0);
        rst_n = 1'b1;
        tick(2);

        // Nominal per-lane run
        msg_log.delete();
        i_lfsr_or_perlane = 1'b1;
        i_en = 1'b1;
        tick(1);
        check("entry_msg", o_sideband_message, 4'h1);
        check("entry_vtx_low", o_valid_tx, 1'b0);
        tick(1);
        check("vtx_two_cycles", o_valid_tx, 1'b1);
        serialize(2);
        respond(4'h2);
        tick(2);
        check("nom_pt_en", o_pt_en, 1'b1);
        check("nom_sweep", o_eye_width_sweep_en, 1'b0);
        pt_done(16'hFFF0);
        check("nom_end_msg", o_sideband_message, 4'h3);
        serialize(2);
        respond(4'h4);
        check("nom_ack", o_test_ack, 1'b1);
        check("nom_lanes", o_lanes_result, 16'hFFF0);
        check("nom_msg_zero", o_sideband_message, 4'h0);
        check("nom_no_timeout", o_timeout, 1'b0);
        check("model_lanes", m_lanes, 16'hFFF0);
        tick(3);
        check("nom_ack_held", o_test_ack, 1'b1);
        check("log_size", msg_log.size(), 2);
        if (msg_log.size() == 2) begin
            check("log_first", msg_log[0], 4'h1);
            check("log_second", msg_log[1], 4'h3);
        end
        disable_block();

        // LFSR mode with a wrong message during the start wait
        i_lfsr_or_perlane = 1'b0;
        i_en = 1'b1;
        serialize(1);
        respond(4'h4);
        tick(2);
        check("wrong_msg_ignored", o_pt_en, 1'b0);
        respond(4'h2);
        check("lfsr_pt_en", o_pt_en, 1'b1);
        check("lfsr_sweep_on", o_eye_width_sweep_en, 1'b1);
        tick(3);
        check("lfsr_sweep_held", o_eye_width_sweep_en, 1'b1);
        pt_done(16'h00A5);
        check("lfsr_sweep_off", o_eye_width_sweep_en, 1'b0);
        check("lfsr_pt_off", o_pt_en, 1'b0);
        serialize(1);
        respond(4'h4);
        check("lfsr_ack", o_test_ack, 1'b1);
        check("lfsr_lanes", o_lanes_result, 16'h00A5);
        disable_block();

        // Partner owns the mux for 5 cycles; its busy edge must not retire our request
        i_lfsr_or_perlane = 1'b1;
        i_en = 1'b1;
        i_valid_rx = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            check("rx_hold_vtx_low", o_valid_tx, 1'b0);
            i_busy_negedge_detected = (k == 2);
        end
        i_busy_negedge_detected = 1'b0;
        i_valid_rx = 1'b0;
        tick(1);
        check("vtx_after_rx_release", o_valid_tx, 1'b1);
        serialize(1);
        tick(2);
        disable_block();

        // Enable dropped during the point test, then restart
        i_en = 1'b1;
        serialize(1);
        respond(4'h2);
        tick(2);
        check("drop_pt_en_before", o_pt_en, 1'b1);
        disable_block();
        i_en = 1'b1;
        tick(1);
        check("restart_msg", o_sideband_message, 4'h1);
        tick(1);
        check("restart_vtx", o_valid_tx, 1'b1);
        disable_block();

        // No response: abort exactly T cycles after entering the start wait
        i_en = 1'b1;
        serialize(1);
        @(posedge clk);
        tick(T - 1);
        check("timeout_not_yet", o_timeout, 1'b0);
        tick(1);
        check("timeout_flag", o_timeout, 1'b1);
        check("timeout_ack", o_test_ack, 1'b1);
        check("model_timeout", m_to, 1'b1);
        tick(2);
        disable_block();

        check_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
